// File: rtl/log2_server.sv
// Shared round-robin log2/size engine: floor_log2, ceil_log2, bit_size and
// encoding_size computed one shift per clock for NUM_REQ requesters.
module log2_server #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int RW      = ((WIDTH + 1) <= 1) ? 1 : $clog2(WIDTH + 1),
    parameter int IW      = (NUM_REQ <= 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_operand,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IW-1:0]              rsp_id,
    output logic [RW-1:0]              rsp_result,
    output logic                       rsp_err,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t             state, state_next;
    logic [IW-1:0]      ptr, ptr_next, grant;
    logic               found, accept, cont;
    logic [1:0]         sel_op, op;
    logic [WIDTH-1:0]   sel_operand, residual;
    logic [RW-1:0]      count, result_calc;

    // Two passes: requesters at or above the pointer first, then the wrap-around
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[k] && (IW'(k) >= ptr)) begin
                found = 1'b1;
                grant = IW'(k);
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[k] && (IW'(k) < ptr)) begin
                found = 1'b1;
                grant = IW'(k);
            end
        end
    end

    always_comb begin
        sel_op      = '0;
        sel_operand = '0;
        req_ready   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant == IW'(k)) begin
                sel_op      = req_op[2*k +: 2];
                sel_operand = req_operand[WIDTH*k +: WIDTH];
            end
            req_ready[k] = rst_n && (state == IDLE) && found && (grant == IW'(k));
        end
    end

    assign accept   = (state == IDLE) && found;
    assign ptr_next = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    // ceil/encoding (op[0]=1) run on operand-1 and stop at zero; floor/bit_size stop at one
    assign cont = rsp_err ? 1'b0 : (op[0] ? (residual != '0) : (residual > WIDTH'(1)));

    always_comb begin
        result_calc = count;
        if (rsp_err) begin
            result_calc = '0;
        end else begin
            case (op)
                2'd2:    result_calc = count + 1'b1;
                2'd3:    result_calc = (count == '0) ? RW'(1) : count;
                default: result_calc = count;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = CALC;
            CALC:    if (!cont)     state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            op         <= '0;
            residual   <= '0;
            count      <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op       <= sel_op;
                        rsp_id   <= grant;
                        ptr      <= ptr_next;
                        count    <= '0;
                        residual <= sel_op[0] ? (sel_operand - 1'b1) : sel_operand;
                        rsp_err  <= (sel_operand == '0) && (sel_op != 2'd2);
                    end
                end
                CALC: begin
                    if (cont) begin
                        residual <= residual >> 1;
                        count    <= count + 1'b1;
                    end else begin
                        rsp_result <= result_calc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_log2_server.sv
// Directed bench for log2_server: arithmetic model plus scoreboard compare on
// every negedge, with hand-computed expectations for the key vectors.
module tb_log2_server;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int RW = 6;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid, req_ready;
    logic [2*NR-1:0]   req_op;
    logic [W*NR-1:0]   req_operand;
    logic              rsp_valid, rsp_ready, rsp_err, busy;
    logic [IW-1:0]     rsp_id;
    logic [RW-1:0]     rsp_result;

    log2_server #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_operand(req_operand),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // ---------------- arithmetic model ----------------
    function automatic int unsigned m_floor(logic [W-1:0] x);
        int unsigned k = 0;
        while ((64'd1 << (k + 1)) <= 64'(x)) k++;
        return k;
    endfunction

    function automatic int unsigned m_ceil(logic [W-1:0] x);
        int unsigned k = 0;
        while ((64'd1 << k) < 64'(x)) k++;
        return k;
    endfunction

    typedef struct {
        int unsigned   id;
        int unsigned   acc;
        int unsigned   due;
        logic [RW-1:0] res;
        logic          err;
    } job_t;

    function automatic job_t model(int unsigned id, logic [1:0] op, logic [W-1:0] x, int unsigned acc);
        job_t j;
        int unsigned it;
        j.id = id; j.acc = acc; j.err = 1'b0; j.res = '0; it = 0;
        if (x == 0 && op != 2'd2) begin
            j.err = 1'b1;
        end else begin
            case (op)
                2'd0: begin it = m_floor(x); j.res = RW'(it); end
                2'd1: begin it = m_ceil(x);  j.res = RW'(it); end
                2'd2: begin
                    it    = (x <= 1) ? 0 : m_floor(x);
                    j.res = (x == 0) ? RW'(1) : RW'(m_floor(x) + 1);
                end
                default: begin it = m_ceil(x); j.res = (x == 1) ? RW'(1) : RW'(it); end
            endcase
        end
        j.due = acc + 1 + it;
        return j;
    endfunction

    // ---------------- scoreboard / compare ----------------
    job_t          q[$];
    int unsigned   grants[$];
    int            ndone = 0;
    bit            shown = 0;
    int unsigned   last_lat, last_id;
    logic [RW-1:0] last_result;
    logic          last_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            shown = 0;
        end else begin
            chk("ready_onehot", 64'($onehot0(req_ready)), 1);
            chk("ready_subset", 64'(req_ready & ~req_valid), 0);
            if (req_ready != '0) chk("ready_idle", 64'(busy), 0);
            if (q.size() == 0) chk("idle_busy", 64'(busy), 0);
            else if (cyc >= q[0].acc) chk("job_busy", 64'(busy), 1);

            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("stray_rsp", 64'(rsp_valid), 0);
                end else begin
                    if (!shown) begin
                        chk("latency", 64'(cyc), 64'(q[0].due));
                        last_lat = cyc - q[0].acc;
                        shown = 1;
                    end
                    chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                    chk("rsp_result", 64'(rsp_result), 64'(q[0].res));
                    chk("rsp_err", 64'(rsp_err), 64'(q[0].err));
                    last_id = rsp_id; last_result = rsp_result; last_err = rsp_err;
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        shown = 0;
                        ndone++;
                    end
                end
            end else if (q.size() > 0 && !shown && cyc == q[0].due) begin
                chk("rsp_late", 64'(rsp_valid), 1);
            end

            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    q.push_back(model(i, req_op[2*i +: 2], req_operand[W*i +: W], cyc + 1));
                    grants.push_back(i);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int id, input logic [1:0] op, input logic [W-1:0] x);
        bit got = 0;
        req_op[2*id +: 2] = op;
        req_operand[W*id +: W] = x;
        req_valid[id] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (req_ready[id]) begin got = 1; break; end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        bit got = 0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            if (ndone >= target) begin got = 1; break; end
        end
        if (!got) chk("rsp_timeout", 64'(ndone), 64'(target));
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 0);
        chk({tag, "_rsp_result"}, 64'(rsp_result), 0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        req_valid = '1;
        #1;
        chk({tag, "_req_ready"}, 64'(req_ready), 0);
        req_valid = '0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [W-1:0] x;
        int unsigned res;
        int unsigned lat;
        logic        err;
    } vec_t;

    vec_t vecs [16] = '{
        '{2'd0, 32'd1,          0,  1, 1'b0},
        '{2'd0, 32'd32,         5,  6, 1'b0},
        '{2'd0, 32'hFFFFFFFF,   31, 32, 1'b0},
        '{2'd1, 32'd1,          0,  1, 1'b0},
        '{2'd1, 32'd2,          1,  2, 1'b0},
        '{2'd1, 32'd5,          3,  4, 1'b0},
        '{2'd1, 32'h80000001,   32, 33, 1'b0},
        '{2'd3, 32'd1,          1,  1, 1'b0},
        '{2'd3, 32'd256,        8,  9, 1'b0},
        '{2'd2, 32'd0,          1,  1, 1'b0},
        '{2'd2, 32'd255,        8,  8, 1'b0},
        '{2'd2, 32'd256,        9,  9, 1'b0},
        '{2'd0, 32'd0,          0,  1, 1'b1},
        '{2'd1, 32'd0,          0,  1, 1'b1},
        '{2'd3, 32'd0,          0,  1, 1'b1},
        '{2'd0, 32'd32,         5,  6, 1'b0}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        bit seen;
        req_valid = '0; req_op = '0; req_operand = '0; rsp_ready = 1'b1; rst_n = 1'b0;
        #1;
        check_reset_outputs("rst0");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // all requesters held high: grant order from pointer 0
        @(posedge clk); #1;
        grants.delete();
        tgt = ndone + 6;
        for (int i = 0; i < NR; i++) begin
            req_op[2*i +: 2] = 2'(i);
            req_operand[W*i +: W] = (i == 2) ? 32'd0 : ((i == 3) ? 32'd1 : 32'd20);
        end
        req_valid = '1;
        wait_rsp(tgt);
        req_valid = '0;
        chk("arb_count", 64'(grants.size()), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("arb_order%0d", k), 64'(grants[k]), 64'(k % NR));

        // directed vectors on requester 0
        for (int v = 0; v < 16; v++) begin
            tgt = ndone + 1;
            issue(0, vecs[v].op, vecs[v].x);
            wait_rsp(tgt);
            chk($sformatf("v%0d_result", v), 64'(last_result), 64'(vecs[v].res));
            chk($sformatf("v%0d_latency", v), 64'(last_lat), 64'(vecs[v].lat));
            chk($sformatf("v%0d_err", v), 64'(last_err), 64'(vecs[v].err));
        end

        // backpressure
        rsp_ready = 1'b0;
        tgt = ndone + 1;
        issue(0, 2'd0, 32'd32);
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1; break; end
        end
        chk("bp_seen", 64'(seen), 1);
        @(posedge clk); #1;
        req_op[3:2] = 2'd2;
        req_operand[2*W-1:W] = 32'd255;
        req_valid[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 1);
            chk("bp_ready", 64'(req_ready), 0);
            chk("bp_busy", 64'(busy), 1);
            chk("bp_result", 64'(rsp_result), 5);
            chk("bp_id", 64'(rsp_id), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_rsp(tgt + 1);
        req_valid = '0;
        chk("bp_next_id", 64'(last_id), 1);
        chk("bp_next_result", 64'(last_result), 8);

        // reset in the middle of a long ceil_log2
        issue(0, 2'd1, 32'h80000001);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_calc");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            chk("no_stray", 64'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        grants.delete();
        for (int i = 0; i < NR; i++) begin
            req_op[2*i +: 2] = 2'd0;
            req_operand[W*i +: W] = 32'd1;
        end
        tgt = ndone + 1;
        req_valid = '1;
        wait_rsp(tgt);
        req_valid = '0;
        chk("post_rst_grant", 64'(grants.size() > 0 ? grants[0] : 99), 0);
        chk("post_rst_id", 64'(last_id), 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/log2_server.md
Name: log2_server

Overview:
- Shared, time-multiplexed engine that evaluates integer log-based sizing functions at run time: floor_log2, ceil_log2, bit_size and encoding_size.
- Serves NUM_REQ requesters through a round-robin arbiter.
- Iterates one shift per clock, so a single narrow datapath replaces per-requester combinational priority encoders.
- Used by runtime-configurable blocks, such as programmable-depth buffers and AXI width setup, that need sizes computed from register values rather than elaboration-time parameters.

Parameters:
- NUM_REQ, default 4: number of requesters; must be ≥1.
- WIDTH, default 32: operand width in bits; must be ≥2.
- RW, default encoding_size(WIDTH+1): result width in bits. Derived; do not override.
- IW, default encoding_size(NUM_REQ): requester-ID width in bits. Derived; do not override.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- req_valid, in, NUM_REQ: per-requester request valid.
- req_ready, out, NUM_REQ: per-requester accept; one-hot or zero.
- req_op, in, 2*NUM_REQ: per-requester opcode, slice i = [2i+1:2i]. 0=floor_log2, 1=ceil_log2, 2=bit_size, 3=encoding_size.
- req_operand, in, WIDTH*NUM_REQ: per-requester unsigned operand, slice i = [WIDTH*i+WIDTH-1:WIDTH*i].
- rsp_valid, out, 1: response valid.
- rsp_ready, in, 1: response consumer ready.
- rsp_id, out, IW: index of the requester that issued this result.
- rsp_result, out, RW: computed value.
- rsp_err, out, 1: operand illegal for the opcode.
- busy, out, 1: high in CALC or RESP.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0; RR pointer=0, giving requester 0 highest priority. Reset asserted mid-CALC or mid-RESP discards the in-flight job; no response is ever produced for it.
- FSM states are IDLE, CALC and RESP. One job is outstanding at most.
- IDLE:
  - Round-robin grant among asserted req_valid bits, searching upward from the pointer and wrapping.
  - req_ready[g] is asserted combinationally only for the granted g; it may depend on req_valid.
  - On the edge where req_valid[g] and req_ready[g] are both high: latch op, id=g and the operand; load the residual; set the pointer to g+1 mod NUM_REQ; go to CALC.
- Residual load and error check:
  - floor_log2 and bit_size load the operand. ceil_log2 and encoding_size load operand−1.
  - Operand 0 with op 0, 1 or 3 sets err: result=0, CALC lasts 1 cycle.
  - bit_size(0) is legal: result=1, err=0.
- CALC, one cycle per iteration:
  - Continue condition is residual>1 for floor/bit_size and residual>0 for ceil/encoding.
  - If the condition holds: residual>>=1, count+=1.
  - Otherwise: register the result and go to RESP.
- Result:
  - floor_log2 = count.
  - ceil_log2 = count.
  - bit_size = count+1.
  - encoding_size = 1 if operand==1, else count.
- Latency: from the accept edge to rsp_valid high is k+1 cycles, where k is the iteration count. Worst case is WIDTH+1 cycles (ceil of 2^WIDTH−1 needs k=WIDTH).
- RESP:
  - rsp_valid=1. rsp_id, rsp_result and rsp_err are stable until the rsp_valid&&rsp_ready edge, after which the state returns to IDLE.
  - No new request is accepted in the handshake cycle; the next accept is no earlier than the following cycle.
- Arithmetic: count fits in RW bits. rsp_result is zero-extended. All comparisons are unsigned.
- Requester obligations: hold req_valid, op and operand stable until accepted. A requester may deassert req_valid before being granted with no side effects.
- With NUM_REQ=1 the arbiter degenerates to a pass-through; rsp_id is constant 0.

Test Plan:
- Single requester, rsp_ready=1. floor_log2(1)→0 at accept+1. floor_log2(32)→5 at accept+6. floor_log2(0xFFFFFFFF)→31 at accept+32. rsp_err=0 for all.
- ceil_log2 and encoding_size sweep. ceil(1)=0, ceil(2)=1, ceil(5)=3, ceil(0x80000001)=32 at accept+33. encoding_size(1)=1, encoding_size(256)=8. bit_size(0)=1, bit_size(255)=8, bit_size(256)=9.
- Errors: floor_log2(0), ceil_log2(0) and encoding_size(0) → rsp_err=1, rsp_result=0, response at accept+1. Engine accepts a new job normally afterwards.
- Arbitration: all 4 req_valid held high continuously → grant order 0,1,2,3,0,…. rsp_id matches the grant order. req_ready is one-hot and only in IDLE.
- Backpressure: rsp_ready=0 for 10 cycles. rsp_valid, rsp_id and rsp_result are held and busy=1. No req_ready is asserted until the response handshake completes.
- Reset mid-CALC on ceil_log2(0x80000001): all outputs go to their reset values immediately. No stray rsp_valid follows. Pointer=0, so requester 0 wins next when all requesters are asserted.
